// File: rtl/serial_adder8.sv
// Bit-serial adder: one full-adder cell and a carry flop,
// LSB first, registered sum/cout/v with a one-cycle done pulse.
module serial_adder8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             v
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] s_sh;
  logic             carry;
  logic [CW-1:0]    count;

  logic s_bit;
  logic c_nx;
  logic last;
  logic load;

  assign s_bit = a_sh[0] ^ b_sh[0] ^ carry;
  assign c_nx  = (a_sh[0] & b_sh[0])
               | (a_sh[0] & carry)
               | (b_sh[0] & carry);
  assign last  = (count == CW'(WIDTH - 1));
  assign load  = start && (state != RUN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic; DONE may chain straight into a new RUN
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RUN;
      RUN:  if (last)  state_nx = DONE;
      DONE: state_nx = start ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Status outputs decoded from the state flops only
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:  busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Operand load, one bit per edge, result capture on the last bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      s_sh  <= '0;
      carry <= 1'b0;
      count <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      v     <= 1'b0;
    end else if (load) begin
      a_sh  <= a;
      b_sh  <= b;
      s_sh  <= '0;
      carry <= cin;
      count <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      s_sh  <= {s_bit, s_sh[WIDTH-1:1]};
      carry <= c_nx;
      count <= count + CW'(1);
      if (last) begin
        sum  <= {s_bit, s_sh[WIDTH-1:1]};
        cout <= c_nx;
        v    <= carry ^ c_nx;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder8.sv
// Self-checking bench for serial_adder8: directed cases with
// literal results plus random traffic against an arithmetic model.
module tb_serial_adder8;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
  logic       v;

  int n_vec;
  int n_err;

  // model: edges since the op was accepted, -1 when none in flight
  int         since;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       op_c;
  logic [7:0] m_sum;
  logic       m_cout;
  logic       m_v;

  serial_adder8 #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .v     (v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // behavioural model: plain 9-bit addition, sign rule for v
  always @(posedge clk or negedge rst_n) begin
    logic [8:0] t;
    if (!rst_n) begin
      since  = -1;
      m_sum  = '0;
      m_cout = 1'b0;
      m_v    = 1'b0;
    end else if (start && (since == -1 || since == 8)) begin
      since = 0;
      op_a  = a;
      op_b  = b;
      op_c  = cin;
    end else if (since >= 0 && since < 8) begin
      since++;
      if (since == 8) begin
        t      = {1'b0, op_a} + {1'b0, op_b} + {8'd0, op_c};
        m_sum  = t[7:0];
        m_cout = t[8];
        m_v    = (op_a[7] == op_b[7]) && (t[7] != op_a[7]);
      end
    end else begin
      since = -1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(since >= 0 && since < 8));
    chk("done", 32'(done), 32'(since == 8));
    chk("sum",  32'(sum),  32'(m_sum));
    chk("cout", 32'(cout), 32'(m_cout));
    chk("v",    32'(v),    32'(m_v));
  end

  task automatic run_op(input logic [7:0] xa,
                        input logic [7:0] xb,
                        input logic       xc,
                        input logic [7:0] es,
                        input logic       ec,
                        input logic       ev,
                        output int        nbusy);
    bit got;
    got   = 0;
    nbusy = 0;
    @(negedge clk);
    start = 1'b1;
    a     = xa;
    b     = xb;
    cin   = xc;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (busy) nbusy++;
      if (done) begin
        got = 1;
        break;
      end
      @(negedge clk);
    end
    chk("op_done_seen", 32'(got), 32'd1);
    chk("op_sum",  32'(sum),  32'(es));
    chk("op_cout", 32'(cout), 32'(ec));
    chk("op_v",    32'(v),    32'(ev));
  endtask

  initial begin
    int nb;
    int ndone;
    int last_t;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_op(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, nb);
    chk("busy_cycles", 32'(nb), 32'd8);
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, nb);
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, nb);
    run_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, nb);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, nb);
    run_op(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, nb);

    // start during RUN must be ignored
    @(negedge clk);
    start = 1'b1;
    a     = 8'h21;
    b     = 8'h13;
    cin   = 1'b0;
    @(negedge clk);
    a     = 8'hF0;
    b     = 8'hF0;
    cin   = 1'b1;
    repeat (4) @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done) begin
        ndone++;
        chk("ign_sum", 32'(sum), 32'h34);
      end
      @(negedge clk);
    end
    chk("ign_ndone", 32'(ndone), 32'd1);

    // start held high: one result every 9 cycles
    start  = 1'b1;
    a      = 8'h01;
    b      = 8'h01;
    cin    = 1'b0;
    ndone  = 0;
    last_t = -1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        chk("bb_sum", 32'(sum), 32'h02);
        if (last_t >= 0) chk("bb_period", 32'(k - last_t), 32'd9);
        last_t = k;
        ndone++;
      end
    end
    chk("bb_ndone", 32'(ndone >= 4), 32'd1);
    start = 1'b0;
    repeat (12) @(negedge clk);

    // reset in the middle of RUN
    start = 1'b1;
    a     = 8'h12;
    b     = 8'h34;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_sum",  32'(sum),  32'd0);
    chk("ar_cout", 32'(cout), 32'd0);
    chk("ar_v",    32'(v),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("ar_nodone", 32'(ndone), 32'd0);
    run_op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, nb);

    // random traffic, start pulsed at random including while busy
    for (int k = 0; k < 1500; k++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) == 0);
      a     = 8'($urandom);
      b     = 8'($urandom);
      cin   = 1'($urandom);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder8.md
# serial_adder8

Bit-serial 8-bit adder for the Mega-8 arithmetic datapath, complementing the existing combinational subtractor chain. It accepts two operands plus carry-in on a one-cycle start strobe, adds one bit per clock LSB-first through a single full-adder cell and carry flip-flop, then presents a registered sum, carry-out and signed-overflow flag with a one-cycle done pulse. It trades latency for area in the low-cost ALU build.

## Interface
- WIDTH, 8, operand/result width in bits; bit counter sized to hold 0..WIDTH-1.
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled on rising edge, accepted only when busy=0.
- a  input  WIDTH  augend, captured on accepted start.
- b  input  WIDTH  addend, captured on accepted start.
- cin  input  1  carry-in, captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid and newly updated.
- sum  output  WIDTH  registered result (a+b+cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- v  output  1  signed overflow: carry into MSB XOR carry out of MSB.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state IDLE.
- IDLE: busy=0, done=0. start=1 -> load shift regs A<=a, B<=b, carry<=cin, count<=0 -> RUN.
- RUN: each edge computes s=A[0]^B[0]^carry and carry<=maj(A[0],B[0],carry); A, B shift right; s shifts into MSB of internal sum shift register; count increments.
- On the edge where count=WIDTH-1: sum<=final shifted value, cout<=new carry, v<=carry-in-to-MSB XOR new carry, state->DONE.
- DONE: done=1, busy=0 for exactly one cycle. start=1 here is accepted (back-to-back) -> RUN with new operands; otherwise -> IDLE.
- start while busy=1: ignored, no effect on operands, counter or outputs.
- sum/cout/v: change only on completion edge; hold last result through IDLE, the next RUN, and until next completion.
- Internal shift registers are not visible; a/b/cin may change freely after the accepting edge.
- Arithmetic: unsigned modular add; cout is unsigned overflow; v is two's-complement overflow (e.g. 0x7F+0x01 sets v=1, cout=0).
- rst_n low at any time, including mid-RUN: operation aborted, state IDLE, all outputs and internal regs zero immediately (async); no done pulse for aborted op.
- First accepted start after rst_n deasserts behaves as from clean IDLE.

## Timing
- Reset values: busy=0, done=0, sum=0, cout=0, v=0, counter=0, carry=0.
- Edge E0 accepts start. busy=1 from after E0 through edge E(WIDTH).
- Result registered at edge E(WIDTH); done high from E(WIDTH) to E(WIDTH+1). Latency start-to-done: WIDTH+1 edges (9 for WIDTH=8).
- Maximum throughput: one add per WIDTH+1 cycles (start held high continuously gives done every 9 cycles).
- start is level-sampled; holding it high in IDLE starts exactly one op per accept opportunity, none while busy.
- All outputs registered; no combinational path from inputs to outputs.
- rst_n assertion is asynchronous; deassertion assumed synchronized to clk upstream.

## Test plan
- Reset then a=0x00, b=0x00, cin=0, start 1 cycle -> busy 8 cycles, done pulse 9th edge, sum=0x00, cout=0, v=0.
- a=0x0F, b=0x01, cin=0 -> sum=0x10, cout=0, v=0; a=0xFF, b=0x01 -> sum=0x00, cout=1, v=0.
- a=0x7F, b=0x01 -> sum=0x80, v=1, cout=0; a=0x80, b=0x80 -> sum=0x00, cout=1, v=1; a=0xAA, b=0x55, cin=1 -> sum=0x00, cout=1, v=0.
- Start accepted, then start=1 with different a/b during RUN -> ignored; result matches first operands, single done pulse.
- start held high continuously with a=0x01, b=0x01 -> done every 9 cycles, sum=0x02 each time; sum unchanged between done pulses.
- rst_n pulsed low at cycle 4 of RUN -> outputs zero immediately, no done; next start with a=0x10, b=0x20 -> sum=0x30 after 9 edges.
